hazard_controller: RTL
======================

# hazard_controller

Pipeline sequencing controller for the 5-stage RISC-V core. Each cycle it decides whether each stage advances, holds, or is squashed, and drives the `is_stall` / `is_flush` inputs of the ID-stage control unit. It handles:
- load-use interlocks,
- EX-stage redirects (taken branch, jal, jalr),
- data/instruction memory wait states,
- the ecall halt sequence: drain the pipeline, then freeze.

It also keeps stall and flush performance counters.

## Interface
Parameters:
- DRAIN_CYCLES, 3: non-frozen cycles between ecall leaving ID and `halted` rising (EX, MEM, WB).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (asserted at 0).
- id_rs1  in  5  rs1 index of the instruction in ID.
- id_rs2  in  5  rs2 index of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1 (decoder sets this with rs1=17 for ecall).
- id_use_rs2  in  1  ID instruction reads rs2.
- id_is_ecall  in  1  ID instruction is ecall.
- id_halt_cond  in  1  forwarded x17 == 10; valid only when id_is_ecall=1.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  5  destination register of the EX instruction.
- ex_redirect  in  1  EX resolved a taken branch, jal, or jalr; the PC must take the EX target.
- imem_busy  in  1  instruction memory not ready this cycle.
- dmem_busy  in  1  data memory not ready this cycle.
- pc_write  out  1  PC register loads its next value.
- ifid_write  out  1  IF/ID register loads.
- is_stall  out  1  control unit zeroes ID/EX control; a bubble is inserted.
- is_flush  out  1  squash IF/ID (becomes a nop) and zero ID/EX control.
- freeze  out  1  hold every pipeline register, including EX/MEM and MEM/WB.
- halted  out  1  the halt sequence is complete.
- stall_count  out  CNT_W  count of load-use stall cycles, saturating.
- flush_count  out  CNT_W  count of redirect flush cycles, saturating.

## Operation
- FSM states: RUN, DRAIN, HALTED. A down-counter `drain_cnt` is $clog2(DRAIN_CYCLES+1) bits wide.
- Load-use hazard `lu`: ex_mem_read & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- RUN priority, highest first. Default outputs are pc_write=1, ifid_write=1, all others 0.
  1. imem_busy | dmem_busy → freeze=1, pc_write=0, ifid_write=0, is_stall=0, is_flush=0. No state change; counters hold.
  2. ex_redirect → is_flush=1, pc_write=1, ifid_write=1 (the IF/ID write is overridden by the flush, so IF/ID becomes a nop). `lu` and ecall are ignored; flush_count += 1.
  3. lu → is_stall=1, pc_write=0, ifid_write=0; stall_count += 1.
  4. id_is_ecall & id_halt_cond → the ecall proceeds to EX; pc_write=0; next state DRAIN; drain_cnt ← DRAIN_CYCLES.
  5. id_is_ecall & !id_halt_cond → treated as a nop; no action.
- DRAIN:
  - Outputs: pc_write=0, ifid_write=0, is_flush=1 (bubbles behind the ecall); ex_redirect and lu are ignored.
  - If either memory is busy: freeze=1, is_flush=0, drain_cnt holds.
  - Otherwise drain_cnt decrements; when drain_cnt == 1 and not busy, next state is HALTED.
- HALTED:
  - Outputs: freeze=1, halted=1, pc_write=0, ifid_write=0, is_stall=0, is_flush=0.
  - Terminal; only reset exits.
- Counters saturate at 2^CNT_W - 1 and do not wrap.
- Reset (reset=0 at a rising edge): state ← RUN, drain_cnt ← 0, both counters ← 0.
  - While reset is low, outputs are forced: pc_write=0, ifid_write=0, freeze=0, is_stall=0, is_flush=1, halted=0.
  - Reset asserted during DRAIN or HALTED returns to RUN on that edge.

## Timing
- All control outputs are combinational from the current inputs and state; they act in the same cycle.
- State and counters update on the rising edge.
- Load-use stall: exactly 1 cycle. In the next cycle the load is in MEM, so `lu` deasserts and forwarding covers the dependency.
- Redirect: 1 flush cycle; the 2 younger instructions are squashed.
- Halt latency:
  - The edge after ecall is seen in ID enters DRAIN.
  - halted=1 exactly DRAIN_CYCLES non-busy cycles later.
  - Each busy cycle delays halted by 1.
- Simultaneous events:
  - busy together with anything: freeze wins.
  - ex_redirect together with lu or ecall: redirect wins, and no stall is counted.
  - lu together with ecall: the stall is taken first, and the ecall is re-evaluated next cycle with forwarded x17.
- Each counter increments at most once per cycle.

## Test plan
- Load-use: lw x5 in EX (ex_mem_read=1, ex_rd=5), ID add uses rs1=5 → exactly 1 cycle with is_stall=1, pc_write=0, ifid_write=0; stall_count=1. Repeat with ex_rd=0 → no stall.
- Redirect + hazard: ex_redirect=1 and lu both true → is_flush=1, pc_write=1, is_stall=0; flush_count=1, stall_count=0.
- Memory wait:
  - dmem_busy=1 for 3 cycles during a load-use → freeze=1 for 3 cycles, counters unchanged.
  - The stall then occurs in cycle 4 and stall_count=1.
- Halt: ecall with id_halt_cond=1 and no busy cycles → DRAIN with is_flush=1 for 3 cycles, then halted=1 and freeze=1, which persist for ≥10 cycles. With id_halt_cond=0 → no halt.
- Halt with busy: imem_busy=1 for 2 cycles during DRAIN → halted rises 5 cycles after DRAIN entry.
- Reset and saturation:
  - reset=0 mid-DRAIN → next cycle state is RUN, halted=0, counters=0.
  - With CNT_W=2, 5 stalls → stall_count=3.

Source files
------------

// File: rtl/hazard_controller_if.sv
// ============================================================================
// hazard_controller_if
// Pipeline-to-hazard-controller signal bundle: ID/EX hazard inputs, memory
// wait states, and the sequencing outputs plus performance counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface hazard_controller_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             id_is_ecall;
    logic             id_halt_cond;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             ex_redirect;
    logic             imem_busy;
    logic             dmem_busy;
    logic             pc_write;
    logic             ifid_write;
    logic             is_stall;
    logic             is_flush;
    logic             freeze;
    logic             halted;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    // Pipeline side: supplies hazard information, consumes sequencing
    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_ecall,
               id_halt_cond, ex_mem_read, ex_rd, ex_redirect,
               imem_busy, dmem_busy,
        input  pc_write, ifid_write, is_stall, is_flush, freeze, halted,
               stall_count, flush_count
    );

    // Controller side
    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_ecall,
               id_halt_cond, ex_mem_read, ex_rd, ex_redirect,
               imem_busy, dmem_busy,
        output pc_write, ifid_write, is_stall, is_flush, freeze, halted,
               stall_count, flush_count
    );
endinterface

`default_nettype wire

// File: rtl/hazard_controller.sv
// ============================================================================
// hazard_controller
// Per-cycle advance/hold/squash decisions for the 5-stage core: load-use
// interlock, EX redirects, memory wait states and the ecall drain-then-halt
// sequence, with saturating stall/flush performance counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_controller #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    hazard_controller_if.slave bus
);

    localparam int               DW         = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0]    DRAIN_INIT = DW'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state;
    logic [DW-1:0]    drain_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    logic busy;
    logic lu;
    logic halt_req;

    assign busy     = bus.imem_busy | bus.dmem_busy;
    assign lu       = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                      ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                       (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
    assign halt_req = bus.id_is_ecall & bus.id_halt_cond;

    // Same-cycle sequencing outputs from current state and hazard inputs
    always_comb begin
        bus.pc_write   = 1'b1;
        bus.ifid_write = 1'b1;
        bus.is_stall   = 1'b0;
        bus.is_flush   = 1'b0;
        bus.freeze     = 1'b0;
        bus.halted     = 1'b0;
        if (!reset) begin
            // Hold the front end and keep ID/EX squashed while in reset
            bus.pc_write   = 1'b0;
            bus.ifid_write = 1'b0;
            bus.is_flush   = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (busy) begin
                        bus.freeze     = 1'b1;
                        bus.pc_write   = 1'b0;
                        bus.ifid_write = 1'b0;
                    end else if (bus.ex_redirect) begin
                        bus.is_flush   = 1'b1;
                    end else if (lu) begin
                        bus.is_stall   = 1'b1;
                        bus.pc_write   = 1'b0;
                        bus.ifid_write = 1'b0;
                    end else if (halt_req) begin
                        // Let the ecall move to EX but fetch nothing more
                        bus.pc_write   = 1'b0;
                    end
                end
                DRAIN: begin
                    bus.pc_write   = 1'b0;
                    bus.ifid_write = 1'b0;
                    if (busy) begin
                        bus.freeze   = 1'b1;
                    end else begin
                        bus.is_flush = 1'b1;
                    end
                end
                default: begin
                    bus.freeze     = 1'b1;
                    bus.halted     = 1'b1;
                    bus.pc_write   = 1'b0;
                    bus.ifid_write = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state, drain countdown and saturating counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= RUN;
            drain_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (!busy) begin
                        if (bus.ex_redirect) begin
                            if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + 1'b1;
                        end else if (lu) begin
                            if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
                        end else if (halt_req) begin
                            state     <= DRAIN;
                            drain_cnt <= DRAIN_INIT;
                        end
                    end
                end
                DRAIN: begin
                    if (!busy) begin
                        drain_cnt <= drain_cnt - 1'b1;
                        if (drain_cnt == DW'(1)) state <= HALTED;
                    end
                end
                default: begin
                    state <= HALTED;
                end
            endcase
        end
    end

    assign bus.stall_count = stall_cnt;
    assign bus.flush_count = flush_cnt;

endmodule

`default_nettype wire
